// File: rtl/fft_pkg.sv
// Shared constants and helpers for the radix-2 SDF FFT stages.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package fft_pkg;

   // Default sample and twiddle formats: data Q6.8, twiddle Q2.6
   localparam int DW_DEF      = 14;
   localparam int TW_DEF      = 8;
   localparam int TW_FRAC_DEF = 6;

   // Frame phase: first half fills the delay line, second half runs the butterfly
   localparam logic PH_FILL = 1'b0;
   localparam logic PH_BFLY = 1'b1;

   // Clamp a signed value to the range of a w-bit two's-complement number
   function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x,
                                                    input int unsigned        w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Fixed-length shift register holding DEPTH entries of W bits; head is the oldest entry.
// Latency: DEPTH enabled cycles from din to head.
// Backpressure: none; contents shift only while en is high and hold otherwise.
module sdf_delay_line #(
   parameter int W     = 30,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] head
);

   logic [DEPTH-1:0][W-1:0] mem;

   // Shift one entry in per enabled cycle; reset clears every entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (en) begin
         mem <= {mem[DEPTH-2:0], din};
      end
   end

   assign head = mem[DEPTH-1];

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay feedback FFT stage (DIF) with external twiddle ROM; R2SDF_SAT_EN selects saturation over wrap.
// Latency: result registered 1 clk after the advancing edge; differences emerge DEPTH samples later.
// Backpressure: none; the stage advances only on in_valid or flush and holds all state otherwise.
module r2sdf_stage
   import fft_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int TW      = TW_DEF,
   parameter int TW_FRAC = TW_FRAC_DEF,
   parameter int DEPTH   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic                       flush,
   input  logic signed [DW-1:0]       in_r,
   input  logic signed [DW-1:0]       in_i,
   output logic [$clog2(DEPTH)-1:0]   tw_addr,
   input  logic signed [TW-1:0]       tw_r,
   input  logic signed [TW-1:0]       tw_i,
   output logic                       out_valid,
   output logic signed [DW:0]         out_r,
   output logic signed [DW:0]         out_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int XW = DW + 1;
   localparam int PW = DW + TW + 2;

   logic [CW-1:0]        cnt;
   logic                 primed;
   logic                 adv;
   logic                 phase;
   logic                 emit;
   logic signed [XW-1:0] a_r, a_i, b_r, b_i;
   logic signed [XW-1:0] push_r, push_i, res_r, res_i;
   logic signed [XW-1:0] rot_r, rot_i, sum_r, sum_i, dif_r, dif_i;
   logic [2*XW-1:0]      dl_head;
   logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
   logic signed [PW-1:0] p_re, p_im, sh_re, sh_im;
   logic signed [PW-1:0] sum_r_x, sum_i_x, dif_r_x, dif_i_x;
   logic [5:0][PW-1:0]   pre;
   logic [5:0][XW-1:0]   fin;

   // Flush behaves like a valid sample of zero so the last half-frame drains out
   assign adv   = in_valid | flush;
   assign a_r   = flush ? '0 : {in_r[DW-1], in_r};
   assign a_i   = flush ? '0 : {in_i[DW-1], in_i};
   assign phase = cnt[CW-1];
   assign tw_addr = cnt[AW-1:0];
   assign emit  = adv & (primed | (phase == PH_BFLY));

   sdf_delay_line #(
      .W     (2 * XW),
      .DEPTH (DEPTH)
   ) u_dl (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .din   ({push_r, push_i}),
      .head  (dl_head)
   );

   assign b_r = dl_head[2*XW-1:XW];
   assign b_i = dl_head[XW-1:0];

   // Full-precision complex rotation of the delay-line head, then floor shift
   assign br_x  = {{(PW-XW){b_r[XW-1]}}, b_r};
   assign bi_x  = {{(PW-XW){b_i[XW-1]}}, b_i};
   assign wr_x  = {{(PW-TW){tw_r[TW-1]}}, tw_r};
   assign wi_x  = {{(PW-TW){tw_i[TW-1]}}, tw_i};
   assign p_re  = br_x * wr_x - bi_x * wi_x;
   assign p_im  = br_x * wi_x + bi_x * wr_x;
   assign sh_re = p_re >>> TW_FRAC;
   assign sh_im = p_im >>> TW_FRAC;

   // Butterfly sum and difference carried one bit wider before narrowing
   assign sum_r_x = {{(PW-XW){a_r[XW-1]}}, a_r} + {{(PW-XW){b_r[XW-1]}}, b_r};
   assign sum_i_x = {{(PW-XW){a_i[XW-1]}}, a_i} + {{(PW-XW){b_i[XW-1]}}, b_i};
   assign dif_r_x = {{(PW-XW){b_r[XW-1]}}, b_r} - {{(PW-XW){a_r[XW-1]}}, a_r};
   assign dif_i_x = {{(PW-XW){b_i[XW-1]}}, b_i} - {{(PW-XW){a_i[XW-1]}}, a_i};

   assign pre = {dif_i_x, dif_r_x, sum_i_x, sum_r_x, sh_im, sh_re};

   // Narrow every result to the delay-line width: saturate or wrap
   for (genvar g = 0; g < 6; g++) begin : g_fit
`ifdef R2SDF_SAT_EN
      logic signed [63:0] sat_v;
      logic               unused_hi;
      assign sat_v     = sat_trunc({{(64-PW){pre[g][PW-1]}}, pre[g]}, XW);
      assign fin[g]    = sat_v[XW-1:0];
      assign unused_hi = ^sat_v[63:XW];
`else
      logic unused_hi;
      assign fin[g]    = pre[g][XW-1:0];
      assign unused_hi = ^pre[g][PW-1:XW];
`endif
   end

   assign rot_r = fin[0];
   assign rot_i = fin[1];
   assign sum_r = fin[2];
   assign sum_i = fin[3];
   assign dif_r = fin[4];
   assign dif_i = fin[5];

   // Fill phase stores the input and emits rotated differences; butterfly phase swaps roles
   always_comb begin
      res_r  = rot_r;
      res_i  = rot_i;
      push_r = a_r;
      push_i = a_i;
      if (phase == PH_BFLY) begin
         res_r  = sum_r;
         res_i  = sum_i;
         push_r = dif_r;
         push_i = dif_i;
      end
   end

   // Sample counter and primed flag advance only with a sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         primed <= 1'b0;
      end else if (adv) begin
         cnt <= cnt + CW'(1);
         if (phase == PH_BFLY) begin
            primed <= 1'b1;
         end
      end
   end

   // Registered output; valid pulses only on cycles that produce a result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_i     <= '0;
      end else begin
         out_valid <= emit;
         if (emit) begin
            out_r <= res_r;
            out_i <= res_i;
         end
      end
   end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Scoreboard bench for r2sdf_stage: DEPTH=4 and DEPTH=2 instances with directed frames.
// Expected outputs are queued when a frame is issued and popped by a monitor on out_valid.
// Covers reset/idle, impulse, stalls, rotation with floor, DC, flush zeroing, overflow, mid-frame reset.
module tb_r2sdf_stage;

   typedef struct {
      int r;
      int i;
   } cpx_t;

   logic clk = 1'b0;
   logic rst_n;

   logic               v4, f4;
   logic signed [13:0] r4, i4;
   logic [1:0]         ta4;
   logic signed [7:0]  twr4, twi4;
   logic               ov4;
   logic signed [14:0] or4, oi4;

   logic               v2, f2;
   logic signed [13:0] r2, i2;
   logic [0:0]         ta2;
   logic signed [7:0]  twr2, twi2;
   logic               ov2;
   logic signed [14:0] or2, oi2;

   cpx_t q4[$];
   cpx_t q2[$];
   cpx_t e4, e2;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   r2sdf_stage #(.DW(14), .TW(8), .TW_FRAC(6), .DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .flush(f4), .in_r(r4), .in_i(i4),
      .tw_addr(ta4), .tw_r(twr4), .tw_i(twi4),
      .out_valid(ov4), .out_r(or4), .out_i(oi4)
   );

   r2sdf_stage #(.DW(14), .TW(8), .TW_FRAC(6), .DEPTH(2)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .flush(f2), .in_r(r2), .in_i(i2),
      .tw_addr(ta2), .tw_r(twr2), .tw_i(twi2),
      .out_valid(ov2), .out_r(or2), .out_i(oi2)
   );

   // Twiddle ROM for N=8: W^k = exp(-j*2*pi*k/8) in Q2.6
   always_comb begin
      twr4 = 8'sd64;
      twi4 = 8'sd0;
      case (ta4)
         2'd1:    begin twr4 = 8'sd45;  twi4 = -8'sd45; end
         2'd2:    begin twr4 = 8'sd0;   twi4 = -8'sd64; end
         2'd3:    begin twr4 = -8'sd45; twi4 = -8'sd45; end
         default: begin twr4 = 8'sd64;  twi4 = 8'sd0;   end
      endcase
   end

   // Twiddle ROM for N=4, with W^0 scaled to 127 to exercise overflow
   always_comb begin
      twr2 = 8'sd127;
      twi2 = 8'sd0;
      if (ta2 == 1'b1) begin
         twr2 = 8'sd0;
         twi2 = -8'sd64;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every out_valid must match the next queued expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && ov4 === 1'b1) begin
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u4_extra_output: got %0d,%0d expected no output", or4, oi4);
         end else begin
            e4 = q4.pop_front();
            check("u4_out_r", or4, e4.r);
            check("u4_out_i", oi4, e4.i);
         end
      end
      if (rst_n === 1'b1 && ov2 === 1'b1) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u2_extra_output: got %0d,%0d expected no output", or2, oi2);
         end else begin
            e2 = q2.pop_front();
            check("u2_out_r", or2, e2.r);
            check("u2_out_i", oi2, e2.i);
         end
      end
   end

   task automatic exp4(input int r, input int i);
      cpx_t c;
      c.r = r;
      c.i = i;
      q4.push_back(c);
   endtask

   task automatic exp2(input int r, input int i);
      cpx_t c;
      c.r = r;
      c.i = i;
      q2.push_back(c);
   endtask

   task automatic drv4(input logic v, input logic f, input int r, input int i);
      v4 = v;
      f4 = f;
      r4 = 14'(r);
      i4 = 14'(i);
      @(posedge clk);
      #1;
   endtask

   task automatic drv2(input logic v, input logic f, input int r, input int i);
      v2 = v;
      f2 = f;
      r2 = 14'(r);
      i2 = 14'(i);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      v4 = 1'b0; f4 = 1'b0; r4 = '0; i4 = '0;
      v2 = 1'b0; f2 = 1'b0; r2 = '0; i2 = '0;
   endtask

   // Wait a bounded number of cycles for all expected outputs to appear
   task automatic drain(input string name);
      for (int c = 0; c < 10 && (q4.size() != 0 || q2.size() != 0); c++) begin
         @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      #1;
      check({name, "_missing_outputs"}, q4.size() + q2.size(), 0);
      q4.delete();
      q2.delete();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Impulse x0=64 then 4 flushes; optionally leave a gap after every sample
   task automatic run_impulse4(input bit stall);
      exp4(64, 0); exp4(0, 0); exp4(0, 0); exp4(0, 0);
      exp4(64, 0); exp4(0, 0); exp4(0, 0); exp4(0, 0);
      for (int n = 0; n < 12; n++) begin
         drv4(n < 8, n >= 8, (n == 0) ? 64 : 0, 0);
         if (stall) begin
            v4 = 1'b0;
            f4 = 1'b0;
            check("stall_tw_addr", int'(ta4), (n + 1) % 4);
            @(posedge clk);
            #1;
            check("stall_tw_addr_hold", int'(ta4), (n + 1) % 4);
         end
      end
      idle_all();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ovf_exp;
`ifdef R2SDF_SAT_EN
      ovf_exp = 16383;
`else
      ovf_exp = -258;
`endif
      idle_all();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", int'(ov4), 0);
      check("reset_out_r", or4, 0);
      check("reset_out_i", oi4, 0);
      check("reset_tw_addr", int'(ta4), 0);
      check("reset_valid_d2", int'(ov2), 0);
      rst_n = 1'b1;

      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         check("idle_valid", int'(ov4), 0);
         check("idle_out_r", or4, 0);
         check("idle_out_i", oi4, 0);
         check("idle_tw_addr", int'(ta4), 0);
      end

      run_impulse4(1'b0);
      drain("impulse");
      pulse_reset();

      run_impulse4(1'b1);
      drain("stall");
      pulse_reset();

      // Rotation: x1=64+64j, x3=1; difference 1 at k=3 floors to -1,-1
      exp4(0, 0);  exp4(64, 64); exp4(0, 0); exp4(1, 0);
      exp4(0, 0);  exp4(90, 0);  exp4(0, 0); exp4(-1, -1);
      drv4(1, 0, 0, 0);
      drv4(1, 0, 64, 64);
      drv4(1, 0, 0, 0);
      drv4(1, 0, 1, 0);
      for (int n = 0; n < 4; n++) drv4(1, 0, 0, 0);
      for (int n = 0; n < 4; n++) drv4(0, 1, 0, 0);
      idle_all();
      drain("rotation");
      pulse_reset();

      // DC: flush carries garbage data that must be ignored
      for (int n = 0; n < 4; n++) exp4(32, 0);
      for (int n = 0; n < 4; n++) exp4(0, 0);
      exp4(0, 0);
      for (int n = 0; n < 8; n++) drv4(1, 0, 16, 0);
      for (int n = 0; n < 5; n++) drv4(1, 1, 999, -777);
      idle_all();
      drain("dc_flush");
      pulse_reset();

      // Overflow, DEPTH=2: difference 16383 rotated by 127
      exp2(-1, 0); exp2(0, 0); exp2(ovf_exp, 0); exp2(0, 0);
      drv2(1, 0, 8191, 0);
      drv2(1, 0, 0, 0);
      drv2(1, 0, -8192, 0);
      drv2(1, 0, 0, 0);
      drv2(0, 1, 0, 0);
      drv2(0, 1, 0, 0);
      idle_all();
      drain("overflow");
      pulse_reset();

      // DEPTH=2 equal samples: largest sum, zero difference
      exp2(16382, 0); exp2(0, 0); exp2(0, 0); exp2(0, 0);
      drv2(1, 0, 8191, 0);
      drv2(1, 0, 0, 0);
      drv2(1, 0, 8191, 0);
      drv2(1, 0, 0, 0);
      drv2(0, 1, 0, 0);
      drv2(0, 1, 0, 0);
      idle_all();
      drain("max_sum");
      pulse_reset();

      // Reset mid-frame discards the partial frame
      drv4(1, 0, 100, 50);
      drv4(1, 0, 200, 0);
      drv4(1, 0, 300, 0);
      idle_all();
      pulse_reset();
      check("midreset_tw_addr", int'(ta4), 0);
      run_impulse4(1'b0);
      drain("midreset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
